// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen: raster timing generator with pixel request, registered syncs and aligned rgb.
// Define VGA_PATTERN_EN to add the pattern_en port and a built-in 8-bar RGB565 colour pattern.
module hdmi_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 40,
    parameter int H_LEFT  = 8,
    parameter int H_VALID = 640,
    parameter int H_RIGHT = 8,
    parameter int H_FRONT = 8,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 25,
    parameter int V_LEFT  = 8,
    parameter int V_VALID = 480,
    parameter int V_RIGHT = 8,
    parameter int V_FRONT = 2,
    parameter int CNT_W   = 12,
    parameter int DATA_W  = 16,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] pix_data,
`ifdef VGA_PATTERN_EN
    input  logic              pattern_en,
`endif
    output logic              pix_req,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic [DATA_W-1:0] rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              rgb_valid,
    output logic              line_start,
    output logic              frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_LEFT + V_VALID + V_RIGHT + V_FRONT;
    localparam int H_ON    = H_SYNC + H_BACK + H_LEFT;
    localparam int V_ON    = V_SYNC + V_BACK + V_LEFT;
    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    logic [CNT_W-1:0] r_cnt_h, r_cnt_v;
    logic             r_hsync, r_vsync, r_rgb_valid, r_line_start, r_frame_start;
    logic             w_h_end, w_v_end, w_active;

    assign w_h_end  = r_cnt_h == CNT_W'(H_TOTAL - 1);
    assign w_v_end  = r_cnt_v == CNT_W'(V_TOTAL - 1);
    // Gated by reset so the source sees no requests while the block is held.
    assign w_active = sys_rst_n
                   && r_cnt_h >= CNT_W'(H_ON) && r_cnt_h < CNT_W'(H_ON + H_VALID)
                   && r_cnt_v >= CNT_W'(V_ON) && r_cnt_v < CNT_W'(V_ON + V_VALID);

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            r_cnt_h       <= '0;
            r_cnt_v       <= '0;
            r_hsync       <= ~HS_ACT;
            r_vsync       <= ~VS_ACT;
            r_rgb_valid   <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt_h       <= w_h_end ? '0 : r_cnt_h + CNT_W'(1);
            if (w_h_end)
                r_cnt_v   <= w_v_end ? '0 : r_cnt_v + CNT_W'(1);
            r_hsync       <= r_cnt_h < CNT_W'(H_SYNC) ? HS_ACT : ~HS_ACT;
            r_vsync       <= r_cnt_v < CNT_W'(V_SYNC) ? VS_ACT : ~VS_ACT;
            r_rgb_valid   <= w_active;
            r_line_start  <= r_cnt_h == '0;
            r_frame_start <= r_cnt_h == '0 && r_cnt_v == '0;
        end
    end

    assign pix_req     = w_active;
    assign pix_x       = w_active ? r_cnt_h - CNT_W'(H_ON) : '1;
    assign pix_y       = w_active ? r_cnt_v - CNT_W'(V_ON) : '1;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_valid   = r_rgb_valid;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_PATTERN_EN
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [CNT_W-1:0] r_pix_x;
    logic [2:0]       w_bar;

    // Column of the pixel now on rgb, one cycle behind its request.
    always_ff @(posedge vga_clk) begin
        r_pix_x <= pix_x;
    end

    assign w_bar = 3'(r_pix_x / CNT_W'(H_VALID / 8));
    assign rgb   = (!sys_rst_n || !r_rgb_valid) ? '0 : pattern_en ? DATA_W'(BARS[w_bar]) : pix_data;
`else
    assign rgb   = (!sys_rst_n || !r_rgb_valid) ? '0 : pix_data;
`endif
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen: small-raster bench; a frame-position model (cycle index mod frame)
// predicts every output each cycle while random resets and random pixel data are applied.
module tb_hdmi_timing_gen;
    localparam int HSW = 4, HBP = 3, HLB = 1, HVA = 16, HRB = 1, HFP = 2;
    localparam int VSW = 2, VBP = 2, VTB = 1, VVA = 6, VBB = 1, VFP = 1;
    localparam int HT = HSW + HBP + HLB + HVA + HRB + HFP;
    localparam int VT = VSW + VBP + VTB + VVA + VBB + VFP;
    localparam int FT = HT * VT;
    localparam int HO = HSW + HBP + HLB;
    localparam int VO = VSW + VBP + VTB;
    localparam int CW = 12, DW = 16;
    localparam logic [15:0] BAR [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          pattern_en = 1'b0;
    logic          pix_req, hsync, vsync, rgb_valid, line_start, frame_start;
    logic [CW-1:0] pix_x, pix_y;
    logic [DW-1:0] rgb;
    logic          n_pix_req, hsync_n, vsync_n, n_rgb_valid, n_line_start, n_frame_start;
    logic [CW-1:0] n_pix_x, n_pix_y;
    logic [DW-1:0] n_rgb;

    logic [15:0] mem [VVA][HVA];
    int n_cmp = 0, n_bad = 0;
    int cur = 0, prev = -1, nv = 0;
    bit seen = 0;

    always #5 clk = ~clk;

    hdmi_timing_gen #(
        .H_SYNC(HSW), .H_BACK(HBP), .H_LEFT(HLB), .H_VALID(HVA), .H_RIGHT(HRB), .H_FRONT(HFP),
        .V_SYNC(VSW), .V_BACK(VBP), .V_LEFT(VTB), .V_VALID(VVA), .V_RIGHT(VBB), .V_FRONT(VFP),
        .CNT_W(CW), .DATA_W(DW), .HS_POL(1), .VS_POL(1)
    ) u_dut (
        .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pix_data),
`ifdef VGA_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .rgb_valid(rgb_valid),
        .line_start(line_start), .frame_start(frame_start)
    );

    hdmi_timing_gen #(
        .H_SYNC(HSW), .H_BACK(HBP), .H_LEFT(HLB), .H_VALID(HVA), .H_RIGHT(HRB), .H_FRONT(HFP),
        .V_SYNC(VSW), .V_BACK(VBP), .V_LEFT(VTB), .V_VALID(VVA), .V_RIGHT(VBB), .V_FRONT(VFP),
        .CNT_W(CW), .DATA_W(DW), .HS_POL(0), .VS_POL(0)
    ) u_neg (
        .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pix_data),
`ifdef VGA_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .pix_req(n_pix_req), .pix_x(n_pix_x), .pix_y(n_pix_y), .rgb(n_rgb),
        .hsync(hsync_n), .vsync(vsync_n), .rgb_valid(n_rgb_valid),
        .line_start(n_line_start), .frame_start(n_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit act(input int s);
        int h = s % HT, v = s / HT;
        return h >= HO && h < HO + HVA && v >= VO && v < VO + VVA;
    endfunction

    // One clock: checks at the falling edge, then the rising edge, then the source answers.
    task automatic step(input logic r);
        int h, v, ph, pv;
        logic a, pa;
        logic [DW-1:0] er;
        logic [CW-1:0] sx, sy;
        rst_n = r;
        #1;
        h = cur % HT;
        v = cur / HT;
        a = r && act(cur);
        check("pix_req", {31'd0, pix_req}, {31'd0, a});
        check("pix_x", {20'd0, pix_x}, a ? h - HO : 32'hFFF);
        check("pix_y", {20'd0, pix_y}, a ? v - VO : 32'hFFF);
        if (prev < 0) begin
            ph = 0;
            pv = 0;
            pa = 1'b0;
            check("hsync_rst", {31'd0, hsync}, 0);
            check("vsync_rst", {31'd0, vsync}, 0);
            check("hsync_n_rst", {31'd0, hsync_n}, 1);
            check("vsync_n_rst", {31'd0, vsync_n}, 1);
            check("line_start_rst", {31'd0, line_start}, 0);
            check("frame_start_rst", {31'd0, frame_start}, 0);
        end else begin
            ph = prev % HT;
            pv = prev / HT;
            pa = act(prev);
            check("hsync", {31'd0, hsync}, {31'd0, ph < HSW});
            check("vsync", {31'd0, vsync}, {31'd0, pv < VSW});
            check("hsync_n", {31'd0, hsync_n}, {31'd0, ph >= HSW});
            check("vsync_n", {31'd0, vsync_n}, {31'd0, pv >= VSW});
            check("line_start", {31'd0, line_start}, {31'd0, ph == 0});
            check("frame_start", {31'd0, frame_start}, {31'd0, prev == 0});
        end
        check("rgb_valid", {31'd0, rgb_valid}, {31'd0, pa});
        er = '0;
        if (r && pa)
            er = pattern_en ? BAR[(ph - HO) / (HVA / 8)] : mem[pv - VO][ph - HO];
        check("rgb", {16'd0, rgb}, {16'd0, er});
        if (!r) begin
            seen = 0;
            nv = 0;
        end else begin
            if (frame_start) begin
                if (seen)
                    check("valid_per_frame", nv, HVA * VVA);
                seen = 1;
                nv = 0;
            end
            if (rgb_valid)
                nv++;
        end
        sx = pix_x;
        sy = pix_y;
        @(posedge clk);
        if (r) begin
            prev = cur;
            cur = (cur + 1) % FT;
        end else begin
            prev = -1;
            cur = 0;
        end
        #1;
        pix_data = (sx < HVA && sy < VVA) ? mem[int'(sy)][int'(sx)] : 16'($urandom);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b1);
    endtask

    initial begin
        for (int y = 0; y < VVA; y++)
            for (int x = 0; x < HVA; x++)
                mem[y][x] = 16'($urandom);
        @(negedge clk);
        repeat (3) step(1'b0);
        run(2 * FT);
        while (cur != 3 * HT + 10)
            step(1'b1);
        repeat (3) step(1'b0);
        run(FT + 1);
        for (int i = 0; i < 8; i++) begin
            run($urandom_range(1, 2 * FT));
            repeat ($urandom_range(1, 4)) step(1'b0);
        end
`ifdef VGA_PATTERN_EN
        pattern_en = 1'b1;
        run(FT + 5);
        pattern_en = 1'b0;
`endif
        run(2 * FT + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
